iccm_arbiter: RTL

Shares the single ICCM SRAM port between the instruction-fetch TL-UL SRAM adapter and a boot-loader programming port (UART/SPI/debug loader). Sequences the boot: the loader owns the ICCM until it signals completion, and only then is core fetch enabled. In run mode the block round-robins between the two requesters. It routes read responses back to the issuing requester, tracking up to `MaxOut` outstanding reads.

---
 rtl/iccm_arb_pkg.sv | 14 +
 rtl/iccm_arb_tagfifo.sv | 49 ++++
 rtl/iccm_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/iccm_arb_pkg.sv
// Types and tag constants shared by the ICCM arbiter and its read-tag FIFO.
package iccm_arb_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    B2R  = 2'd1,
    RUN  = 2'd2,
    R2B  = 2'd3
  } arb_state_e;

  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_PROG  = 1'b1;

endpackage

// File: rtl/iccm_arb_tagfifo.sv
// 1-bit read-tag FIFO: remembers which requester owns each outstanding ICCM read.
module iccm_arb_tagfifo #(
  parameter int MaxOut = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);

  localparam int PW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
  localparam int CW = $clog2(MaxOut + 1);

  logic [MaxOut-1:0] tags_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOut - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tags_q[wr_ptr_q] <= push_tag;
  end

  assign head_tag = tags_q[rd_ptr_q];
  assign full     = (count_q == CW'(MaxOut));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/iccm_arbiter.sv
// ICCM port arbiter: boot-loader ownership during BOOT, round-robin fetch/loader in RUN.
// Optional ICCM_ARBITER_WLOCK_EN: suppress loader writes in RUN and flag them on p_err_o.
module iccm_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MaxOut   = 2,
  parameter int BootHold = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_req_i,
  input  logic [AW-1:0]   f_addr_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  output logic [DW-1:0]   f_rdata_o,
  input  logic            p_req_i,
  input  logic            p_we_i,
  input  logic [AW-1:0]   p_addr_i,
  input  logic [DW-1:0]   p_wdata_i,
  input  logic [DW/8-1:0] p_wmask_i,
  output logic            p_gnt_o,
  output logic            p_rvalid_o,
  output logic [DW-1:0]   p_rdata_o,
  output logic            p_err_o,
  input  logic            prog_done_i,
  input  logic            boot_req_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wmask_o,
  input  logic [DW-1:0]   mem_rdata_i,
  input  logic            mem_rvalid_i,
  output logic            fetch_en_o,
  output logic            boot_o
);

  arb_state_e state_q, state_d;
  logic fetch_en_q, prefer_prog_q, wlock_err_q;
  logic fifo_full, fifo_empty, head_tag;
  logic rd_room, f_ok, p_ok, f_gnt, p_gnt, wlock, rd_push, rd_pop;

`ifdef ICCM_ARBITER_WLOCK_EN
  assign wlock = (state_q == RUN) && p_we_i;
`else
  assign wlock = 1'b0;
`endif

  // A same-cycle response frees a slot, so a full FIFO can still accept a read.
  assign rd_room = !fifo_full || mem_rvalid_i;
  assign f_ok    = f_req_i && rd_room;
  assign p_ok    = p_req_i && (p_we_i || rd_room);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= (BootHold != 0) ? BOOT : RUN;
      fetch_en_q    <= (BootHold == 0);
      prefer_prog_q <= 1'b0;
      wlock_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_en_q  <= (state_d == RUN);
      wlock_err_q <= p_gnt && wlock;
      if (f_gnt)      prefer_prog_q <= 1'b1;
      else if (p_gnt) prefer_prog_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: if (prog_done_i) state_d = B2R;
      B2R:  if (fifo_empty)  state_d = RUN;
      RUN:  if (boot_req_i)  state_d = R2B;
      R2B:  if (fifo_empty)  state_d = BOOT;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    f_gnt = 1'b0;
    p_gnt = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        BOOT: p_gnt = p_ok;
        RUN: begin
          if (f_ok && p_ok) begin
            p_gnt = prefer_prog_q;
            f_gnt = !prefer_prog_q;
          end else begin
            f_gnt = f_ok;
            p_gnt = p_ok;
          end
        end
        default: ;
      endcase
    end
  end

  assign f_gnt_o     = f_gnt;
  assign p_gnt_o     = p_gnt;
  assign mem_req_o   = f_gnt || (p_gnt && !wlock);
  assign mem_we_o    = p_gnt && p_we_i && !wlock;
  assign mem_addr_o  = p_gnt ? p_addr_i : (f_gnt ? f_addr_i : '0);
  assign mem_wdata_o = mem_we_o ? p_wdata_i : '0;
  assign mem_wmask_o = mem_we_o ? p_wmask_i : '0;

  assign rd_push = f_gnt || (p_gnt && !p_we_i);
  assign rd_pop  = mem_rvalid_i && !fifo_empty && !rst_i;

  iccm_arb_tagfifo #(.MaxOut(MaxOut)) u_tagfifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (rd_push),
    .push_tag (p_gnt ? TAG_PROG : TAG_FETCH),
    .pop      (rd_pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Responses with no tag behind them (e.g. issued before a reset) are dropped and flagged.
  assign f_rvalid_o = rd_pop && (head_tag == TAG_FETCH);
  assign p_rvalid_o = rd_pop && (head_tag == TAG_PROG);
  assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : '0;
  assign p_rdata_o  = p_rvalid_o ? mem_rdata_i : '0;
  assign p_err_o    = !rst_i && ((mem_rvalid_i && fifo_empty) || wlock_err_q);

  assign fetch_en_o = fetch_en_q;
  assign boot_o     = (state_q == BOOT) || (state_q == R2B);

endmodule
